// File: rtl/alu_serial_subtract.sv
// Digit-serial subtractor Z = X - Y (as X + ~Y + 1), BITS_PER_CYCLE result bits per RUN cycle,
// with start/busy/done handshake and the adder's Sign/Zero/Carry(borrow)/Parity/Overflow flags.
module alu_serial_subtract #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             Sign,
  output logic             Zero,
  output logic             Carry,
  output logic             Parity,
  output logic             Overflow
);
  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0]   xr, yr, res;
  logic [CW-1:0]      cnt;
  logic               cy, x_msb, y_msb;
  logic [B:0]         sum;
  logic [WIDTH+B-1:0] res_sh;
  logic               last;

  assign last   = (cnt == CW'(N));
  assign sum    = {1'b0, xr[B-1:0]} + {1'b0, ~yr[B-1:0]} + {{B{1'b0}}, cy};
  // New digit enters at the MSB end; after N shifts the LSB digit sits at the bottom.
  assign res_sh = {sum[B-1:0], res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr <= '0; yr <= '0; res <= '0; cnt <= '0;
      cy <= 1'b0; x_msb <= 1'b0; y_msb <= 1'b0;
      Z <= '0; Sign <= 1'b0; Zero <= 1'b0; Carry <= 1'b0; Parity <= 1'b0; Overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          xr    <= X;
          yr    <= Y;
          x_msb <= X[WIDTH-1];
          y_msb <= Y[WIDTH-1];
          cnt   <= '0;
          cy    <= 1'b1;
        end
        RUN: begin
          if (last) begin
            Z        <= res;
            Carry    <= ~cy;
            Sign     <= res[WIDTH-1];
            Zero     <= (res == '0);
            Parity   <= ~^res;
            Overflow <= (x_msb ^ y_msb) & (res[WIDTH-1] ^ x_msb);
          end else begin
            res <= res_sh[WIDTH+B-1:B];
            xr  <= xr >> B;
            yr  <= yr >> B;
            cy  <= sum[B];
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_subtract.sv
// Drives one digit-serial and one 4-bit-digit subtractor in lockstep and scores results/latency.
module tb_alu_serial_subtract;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] X, Y;

  logic busy1, done1, s1, zr1, cy1, p1, v1;
  logic busy4, done4, s4, zr4, cy4, p4, v4;
  logic [W-1:0] z1, z4;

  alu_serial_subtract #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .busy(busy1), .done(done1),
    .Z(z1), .Sign(s1), .Zero(zr1), .Carry(cy1), .Parity(p1), .Overflow(v1));
  alu_serial_subtract #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .busy(busy4), .done(done4),
    .Z(z4), .Sign(s4), .Zero(zr4), .Carry(cy4), .Parity(p4), .Overflow(v4));

  always #5 clk = ~clk;

  wire [20:0] o1 = {z1, cy1, s1, zr1, p1, v1};
  wire [20:0] o4 = {z4, cy4, s4, zr4, p4, v4};

  int nvec = 0, nerr = 0;
  logic [20:0] q1[$], q4[$];

  function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] z;
    z = x - y;
    return {z, (x < y), z[15], (z == 16'h0), ~^z, (x[15] ^ y[15]) & (z[15] ^ x[15])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start sampled at edge 0 (the posedge consumed here).
  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    q1.push_back(model(x, y));
    q4.push_back(model(x, y));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watches edges 1..22; optionally re-pulses start with other operands mid-RUN.
  task automatic collect(input int pulse_at);
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        if (q4.size() == 0) chk("spurious done4", 1, 0);
        else begin
          chk("latency4", k, 5);
          chk("result4", o4, q4.pop_front());
        end
      end
      if (done1) begin
        if (q1.size() == 0) chk("spurious done1", 1, 0);
        else begin
          chk("latency1", k, 17);
          chk("result1", o1, q1.pop_front());
        end
      end
      if (pulse_at != 0 && k == pulse_at) begin
        X = 16'h1234; Y = 16'h0001; start = 1'b1;
      end
      if (pulse_at != 0 && k == pulse_at + 2) start = 1'b0;
    end
    chk("pending", q1.size() + q4.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; X = '0; Y = '0;
    #1;
    chk("reset out1", {busy1, done1, o1}, 0);
    chk("reset out4", {busy4, done4, o4}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    issue(16'h8fff, 16'h8000); collect(0);
    issue(16'hfffe, 16'h0002); collect(0);
    issue(16'h4000, 16'h4000); collect(0);
    issue(16'h8000, 16'h0001); collect(0);
    issue(16'h0001, 16'h0002); collect(0);
    issue(16'h7fff, 16'hffff); collect(0);
    issue(16'h1357, 16'h9bdf); collect(0);

    // start re-pulsed while both are in RUN with new operands: must be ignored
    issue(16'hfffe, 16'h0002); collect(2);

    // reset mid-RUN: outputs clear immediately, no done follows
    issue(16'h0001, 16'h0002);
    q1.delete(); q4.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrun rst out1", {busy1, done1, o1}, 0);
    chk("midrun rst out4", {busy4, done4, o4}, 0);
    @(negedge clk) rst = 1'b0;
    collect(0);
    chk("post rst hold1", o1, 0);

    issue(16'h8000, 16'h0001); collect(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
